bus_io_responder: RTL and testbench
===================================

// Module: bus_io_responder
// PURPOSE
// Memory-mapped I/O responder on the 6502 CPU bus. It sits beside rom_or_ram and answers CPU
// reads and writes in a 16-byte window, serving display, LED, key and step-counter registers.
// It drives the 8-digit seven-segment display (seg_sel/seg_data), the 4 LEDs and the key inputs.
// The top level muxes rdata onto the CPU DI bus when hit_q=1.
// PARAMETERS
// BASE      16'h6000  window base; must be 16-byte aligned; decode = addr[15:4]==BASE[15:4]
// SCAN_DIV  50000     clk cycles per display digit; legal range 2..2^20
// PORTS
// clk       in   1   system clock; all logic is on the rising edge
// rst_n     in   1   asynchronous active-low reset
// cpu_step  in   1   one-clk pulse marking each CPU clock edge (the one-shot pulse, resynchronised to clk)
// addr      in   16  CPU address bus AB
// wdata     in   8   CPU data out DO
// we        in   1   CPU write enable WE
// rdata     out  8   read data for the CPU DI bus
// hit_q     out  1   1 = rdata is valid for the previous CPU cycle
// key_n     in   3   raw push-buttons, active low, asynchronous
// led       out  4   LED register bits [3:0]
// seg_sel   out  8   digit select, one-hot, active low
// seg_data  out  8   segment pattern of the selected digit, raw (active low)
// BEHAVIOUR
// Reset values: rdata=0, hit_q=0, led=0, seg_sel=8'hFE, seg_data=8'hFF.
//   DIG0..7=8'hFF, LEDR=0, KEYF=0, step counter=0, shadow=0, scan counter=0.
// Bus sampling: inputs are sampled only when cpu_step=1; between steps all bus state holds.
// hit = addr[15:4]==BASE[15:4]. On each step, hit_q <= hit & ~we.
// Read latency: 1 step. On a step with hit & ~we, rdata <= reg[addr[3:0]].
//   On a step that is not a read hit, rdata <= 0.
// Register map (offset):
//   0x0-0x7  DIG0..7  RW  segment byte for digit n
//   0x8      LEDR     RW  bits [3:0] drive led; bits [7:4] read 0
//   0x9      KEYF     R   sticky key-press flags in bits [2:0]; a read clears them
//   0xA      STEPL    R   step counter [7:0]; the same read latches counter [15:8] into the shadow
//   0xB      STEPH    R   returns the shadow
//   0xC-0xF  -        reads return 0; writes are ignored
// Writes: on a step with hit & we, writable registers take wdata in that clk.
//   Writes to read-only registers have no effect and do not clear KEYF.
// Keys: 2-FF synchroniser per bit, then detect a 1->0 transition of the synchronised value.
//   A detected press sets KEYF[i]. If a set and a read-clear of the same bit fall in the same
//   clk, the set wins (the bit stays 1; the read returns the pre-clear value).
// Step counter: 16-bit, increments on every cpu_step, wraps FFFF->0000.
//   A read of STEPL returns the value before that step's increment.
// Display scan: counter 0..SCAN_DIV-1 on clk, independent of cpu_step.
//   At wrap, the digit index advances 0..7 and wraps to 0.
//   seg_sel = ~(1<<idx); seg_data = DIG[idx], registered so it changes in the same clk as seg_sel.
//   A write to DIG[idx] appears on seg_data 1 clk later.
// Reset mid-operation clears all state immediately (asynchronous); the first step after
//   rst_n rises behaves normally.
// TESTING
// 1. Reset -> rdata=00, hit_q=0, led=0, seg_sel=FE, seg_data=FF.
//    Write 8'h5A to 0x6008, then read it back -> rdata=0A one step later, led=4'hA.
// 2. Write DIG3=8'hC0 with SCAN_DIV=4 -> seg_sel=F7 together with seg_data=C0 at clk 12..15
//    after reset; seg_sel wraps F7..7F..FE.
// 3. Pulse key_n[1] low for 5 clk -> KEYF read=02. A second read -> 00.
//    A press landing in the clearing clk -> the next read returns 02.
// 4. 0x1FFFF steps, then read STEPL then STEPH -> FF, then FF from the shadow.
//    The next step wraps the counter to 0000.
// 5. Read address 0x7009 (miss) -> hit_q=0, rdata=00, KEYF unchanged.
//    Write to 0x600A -> counter unaffected.
// 6. Assert rst_n low mid-scan with LEDR=F -> led=0 and seg_sel=FE in the same clk,
//    without waiting for a clock edge.

Source files
------------

// File: rtl/bus_io_responder.sv
// Memory-mapped I/O responder for the 6502 bus: a 16-byte window holding display digits,
// LEDs, sticky key flags and a free-running step counter, plus the seven-segment scan driver.
module bus_io_responder #(
    parameter logic [15:0] BASE     = 16'h6000,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_step,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    output logic [7:0]  rdata,
    output logic        hit_q,
    input  logic [2:0]  key_n,
    output logic [3:0]  led,
    output logic [7:0]  seg_sel,
    output logic [7:0]  seg_data
);

    localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [3:0] OFF_LEDR  = 4'h8;
    localparam logic [3:0] OFF_KEYF  = 4'h9;
    localparam logic [3:0] OFF_STEPL = 4'hA;
    localparam logic [3:0] OFF_STEPH = 4'hB;

    logic [7:0]        dig_q [8];
    logic [7:0]        dig_d [8];
    logic [3:0]        ledr_q, ledr_d;
    logic [2:0]        keyf_q, keyf_d;
    logic [2:0]        key_s1_q, key_s2_q, key_s3_q;
    logic [15:0]       step_cnt_q, step_cnt_d;
    logic [7:0]        shadow_q, shadow_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              hit_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [7:0]        seg_sel_q, seg_sel_d;
    logic [7:0]        seg_data_q, seg_data_d;

    logic       win_hit;
    logic       rd_en;
    logic       wr_en;
    logic [3:0] off;
    logic [7:0] rd_val;
    logic [2:0] key_fall;

    assign win_hit  = (addr[15:4] == BASE[15:4]);
    assign rd_en    = cpu_step & win_hit & ~we;
    assign wr_en    = cpu_step & win_hit & we;
    assign off      = addr[3:0];
    // key_s3_q holds the previous synchronised sample, so a high-then-low pair is a press
    assign key_fall = key_s3_q & ~key_s2_q;

    always_comb begin
        rd_val = 8'h00;
        case (off)
            4'h0, 4'h1, 4'h2, 4'h3,
            4'h4, 4'h5, 4'h6, 4'h7: rd_val = dig_q[off[2:0]];
            OFF_LEDR:               rd_val = {4'h0, ledr_q};
            OFF_KEYF:               rd_val = {5'b0, keyf_q};
            OFF_STEPL:              rd_val = step_cnt_q[7:0];
            OFF_STEPH:              rd_val = shadow_q;
            default:                rd_val = 8'h00;
        endcase
    end

    always_comb begin
        dig_d      = dig_q;
        ledr_d     = ledr_q;
        keyf_d     = keyf_q;
        step_cnt_d = step_cnt_q;
        shadow_d   = shadow_q;
        rdata_d    = rdata_q;
        hit_d      = hit_q;

        if (cpu_step) begin
            step_cnt_d = step_cnt_q + 16'd1;
            hit_d      = win_hit & ~we;
            rdata_d    = rd_en ? rd_val : 8'h00;
        end

        if (wr_en) begin
            if (!off[3]) begin
                dig_d[off[2:0]] = wdata;
            end else if (off == OFF_LEDR) begin
                ledr_d = wdata[3:0];
            end
        end

        if (rd_en && (off == OFF_KEYF)) begin
            keyf_d = 3'b000;
        end
        if (rd_en && (off == OFF_STEPL)) begin
            shadow_d = step_cnt_q[15:8];
        end

        // A press in the same clk as a read-clear must survive, so it is OR-ed in last
        keyf_d = keyf_d | key_fall;
    end

    always_comb begin
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
            idx_d      = idx_q;
        end
        // Both outputs follow the next index so select and pattern change on the same edge
        seg_sel_d  = ~(8'h01 << idx_d);
        seg_data_d = dig_q[idx_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= 8'hFF;
            end
            ledr_q     <= 4'h0;
            keyf_q     <= 3'b000;
            key_s1_q   <= 3'b111;
            key_s2_q   <= 3'b111;
            key_s3_q   <= 3'b111;
            step_cnt_q <= 16'h0000;
            shadow_q   <= 8'h00;
            rdata_q    <= 8'h00;
            hit_q      <= 1'b0;
            scan_cnt_q <= '0;
            idx_q      <= 3'd0;
            seg_sel_q  <= 8'hFE;
            seg_data_q <= 8'hFF;
        end else begin
            dig_q      <= dig_d;
            ledr_q     <= ledr_d;
            keyf_q     <= keyf_d;
            key_s1_q   <= key_n;
            key_s2_q   <= key_s1_q;
            key_s3_q   <= key_s2_q;
            step_cnt_q <= step_cnt_d;
            shadow_q   <= shadow_d;
            rdata_q    <= rdata_d;
            hit_q      <= hit_d;
            scan_cnt_q <= scan_cnt_d;
            idx_q      <= idx_d;
            seg_sel_q  <= seg_sel_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign rdata    = rdata_q;
    assign led      = ledr_q;
    assign seg_sel  = seg_sel_q;
    assign seg_data = seg_data_q;

endmodule

// File: tb/tb_bus_io_responder.sv
// Bench for bus_io_responder: directed scenarios plus random bus traffic, checked against
// a register-map level model of the window, key flags, step counter and display scan.
module tb_bus_io_responder;

    localparam logic [15:0] BASE     = 16'h6000;
    localparam int          SCAN_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        cpu_step;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic [7:0]  rdata;
    logic        hit_q;
    logic [2:0]  key_n;
    logic [3:0]  led;
    logic [7:0]  seg_sel;
    logic [7:0]  seg_data;

    bus_io_responder #(.BASE(BASE), .SCAN_DIV(SCAN_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_step (cpu_step),
        .addr     (addr),
        .wdata    (wdata),
        .we       (we),
        .rdata    (rdata),
        .hit_q    (hit_q),
        .key_n    (key_n),
        .led      (led),
        .seg_sel  (seg_sel),
        .seg_data (seg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset was released; the scan position is a pure function of this
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    // Reference model
    logic [7:0]  m_dig [8];
    logic [3:0]  m_led;
    logic [2:0]  m_keyf;
    logic [15:0] m_cnt;
    logic [7:0]  m_shadow;
    logic [7:0]  m_rdata;
    logic        m_hit;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 8'hFF;
        m_led = 0; m_keyf = 0; m_cnt = 0; m_shadow = 0; m_rdata = 0; m_hit = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] off);
        if (off < 4'h8)  return m_dig[off[2:0]];
        if (off == 4'h8) return {4'h0, m_led};
        if (off == 4'h9) return {5'b0, m_keyf};
        if (off == 4'hA) return m_cnt[7:0];
        if (off == 4'hB) return m_shadow;
        return 8'h00;
    endfunction

    function automatic logic [7:0] exp_sel();
        int idx;
        idx = (cyc / SCAN_DIV) % 8;
        return ~(8'h01 << idx);
    endfunction

    function automatic logic [7:0] exp_seg();
        int idx;
        idx = (cyc / SCAN_DIV) % 8;
        return m_dig[idx];
    endfunction

    task automatic do_step(input logic [15:0] a, input logic [7:0] d, input logic w,
                           input logic [2:0] late_press);
        logic hit;
        @(negedge clk);
        addr = a; wdata = d; we = w; cpu_step = 1'b1;
        @(posedge clk); #1;
        chk("seg_sel", seg_sel, exp_sel());
        chk("seg_data", seg_data, exp_seg());
        hit = (a[15:4] == BASE[15:4]);
        m_hit = hit && !w;
        if (m_hit) begin
            m_rdata = m_read(a[3:0]);
            if (a[3:0] == 4'h9) m_keyf = 3'b000;
            if (a[3:0] == 4'hA) m_shadow = m_cnt[15:8];
        end else begin
            m_rdata = 8'h00;
        end
        if (hit && w) begin
            if (a[3:0] < 4'h8)       m_dig[a[2:0]] = d;
            else if (a[3:0] == 4'h8) m_led = d[3:0];
        end
        m_keyf = m_keyf | late_press;
        m_cnt  = m_cnt + 16'd1;
        chk("rdata", rdata, m_rdata);
        chk("hit_q", hit_q, m_hit);
        chk("led", led, m_led);
        // Garbage on the bus while no step is pending must change nothing
        @(negedge clk);
        cpu_step = 1'b0;
        addr = 16'($urandom); wdata = 8'($urandom); we = 1'($urandom);
        @(posedge clk); #1;
        chk("rdata_hold", rdata, m_rdata);
        chk("hit_hold", hit_q, m_hit);
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("scan_sel", seg_sel, exp_sel());
            chk("scan_data", seg_data, exp_seg());
        end
    endtask

    task automatic press_key(input logic [2:0] mask);
        @(negedge clk);
        key_n = key_n & ~mask;
        repeat (5) @(negedge clk);
        key_n = key_n | mask;
        repeat (4) @(posedge clk);
        m_keyf = m_keyf | mask;
    endtask

    task automatic burst(input int n);
        @(negedge clk);
        addr = 16'h0000; we = 1'b0; cpu_step = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        cpu_step = 1'b0;
        m_cnt = m_cnt + 16'(n);
        m_rdata = 8'h00; m_hit = 1'b0;
        chk("burst_rdata", rdata, m_rdata);
        chk("burst_hit", hit_q, m_hit);
    endtask

    function automatic logic [15:0] rand_addr();
        if ($urandom_range(0, 3) != 0) return {BASE[15:4], 4'($urandom)};
        return 16'($urandom);
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; cpu_step = 1'b0; addr = 16'h0; wdata = 8'h0; we = 1'b0; key_n = 3'b111;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_hit", hit_q, 1'b0);
        chk("rst_led", led, 4'h0);
        chk("rst_sel", seg_sel, 8'hFE);
        chk("rst_data", seg_data, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;

        // Display: DIG3 shows up while digit 3 is selected, and the scan wraps back to digit 0
        do_step(16'h6003, 8'hC0, 1'b1, 3'b000);
        idle_check(40);

        // LED register write and read-back
        do_step(16'h6008, 8'h5A, 1'b1, 3'b000);
        chk("led_5a", led, 4'hA);
        do_step(16'h6008, 8'h00, 1'b0, 3'b000);
        chk("ledr_rd", rdata, 8'h0A);

        // Sticky key flag, read-clear, and a press landing in the clearing clk
        press_key(3'b010);
        do_step(16'h6009, 8'h00, 1'b0, 3'b000);
        chk("keyf_first", rdata, 8'h02);
        do_step(16'h6009, 8'h00, 1'b0, 3'b000);
        chk("keyf_clear", rdata, 8'h00);
        press_key(3'b010);
        @(negedge clk);
        key_n = 3'b101;
        @(posedge clk);
        @(posedge clk);
        do_step(16'h6009, 8'h00, 1'b0, 3'b010);
        key_n = 3'b111;
        do_step(16'h6009, 8'h00, 1'b0, 3'b000);
        chk("keyf_collide", rdata, 8'h02);
        do_step(16'h6009, 8'h00, 1'b0, 3'b000);

        // Miss leaves KEYF alone; a write to STEPL does not disturb the counter
        press_key(3'b001);
        do_step(16'h7009, 8'h00, 1'b0, 3'b000);
        do_step(16'h6009, 8'h00, 1'b0, 3'b000);
        chk("keyf_after_miss", rdata, 8'h01);
        do_step(16'h600A, 8'h55, 1'b1, 3'b000);
        do_step(16'h600A, 8'h00, 1'b0, 3'b000);

        // Counter reaches FFFF, then STEPL/STEPH reads and the wrap
        burst(int'(16'hFFFF - m_cnt));
        do_step(16'h600A, 8'h00, 1'b0, 3'b000);
        chk("stepl_ff", rdata, 8'hFF);
        do_step(16'h600B, 8'h00, 1'b0, 3'b000);
        chk("steph_ff", rdata, 8'hFF);
        do_step(16'h600A, 8'h00, 1'b0, 3'b000);
        chk("stepl_wrap", rdata, 8'h01);

        // Random traffic with occasional key presses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) press_key(3'(1 << $urandom_range(0, 2)));
            do_step(rand_addr(), 8'($urandom), 1'($urandom), 3'b000);
        end

        // Asynchronous reset in the middle of a scan period
        do_step(16'h6008, 8'h0F, 1'b1, 3'b000);
        do_step(16'h6005, 8'h12, 1'b1, 3'b000);
        idle_check(5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_led", led, 4'h0);
        chk("arst_sel", seg_sel, 8'hFE);
        chk("arst_data", seg_data, 8'hFF);
        chk("arst_rdata", rdata, 8'h00);
        chk("arst_hit", hit_q, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_step(16'h600A, 8'h00, 1'b0, 3'b000);
        chk("post_rst_stepl", rdata, 8'h00);
        do_step(16'h6005, 8'h00, 1'b0, 3'b000);
        chk("post_rst_dig5", rdata, 8'hFF);
        for (int i = 0; i < 40; i++) begin
            do_step(rand_addr(), 8'($urandom), 1'($urandom), 3'b000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
